// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate byte cache with a block-level miss FSM.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
`ifdef DCACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    input  logic        mem_busywait
);

    localparam int NUM_BLOCKS = 1 << INDEX_BITS;
    localparam int TAG_BITS   = 6 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ,
        UPDATE
    } state_t;

    state_t state, state_next;

    logic [NUM_BLOCKS-1:0] valid_bits;
    logic [NUM_BLOCKS-1:0] dirty_bits;
    logic [TAG_BITS-1:0]   tag_array  [NUM_BLOCKS];
    logic [31:0]           data_array [NUM_BLOCKS];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic [1:0]            addr_offset;
    logic [31:0]           sel_block;
    logic                  request;
    logic                  hit;
    logic                  write_hit;

    assign addr_tag    = ADDRESS[7:8-TAG_BITS];
    assign addr_index  = ADDRESS[2 +: INDEX_BITS];
    assign addr_offset = ADDRESS[1:0];
    assign sel_block   = data_array[addr_index];
    assign request     = READ | WRITE;
    assign hit         = valid_bits[addr_index] && (tag_array[addr_index] == addr_tag);
    assign write_hit   = (state == IDLE) && WRITE && hit;

    // Invalid lines read as zero so stale data never leaks out after reset
    assign READDATA = hit ? sel_block[{addr_offset, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        BUSYWAIT      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = ADDRESS[7:2];
        mem_writedata = sel_block;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    BUSYWAIT   = 1'b1;
                    state_next = (valid_bits[addr_index] && dirty_bits[addr_index])
                                 ? WRITE_BACK : MEM_READ;
                end
            end
            WRITE_BACK: begin
                BUSYWAIT    = 1'b1;
                mem_write   = 1'b1;
                mem_address = {tag_array[addr_index], addr_index};
                if (!mem_busywait) state_next = MEM_READ;
            end
            MEM_READ: begin
                BUSYWAIT = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) state_next = UPDATE;
            end
            UPDATE: begin
                BUSYWAIT   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == UPDATE) begin
            valid_bits[addr_index] <= 1'b1;
            dirty_bits[addr_index] <= 1'b0;
        end else if (write_hit) begin
            dirty_bits[addr_index] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset: reset holds state in IDLE with valid clear
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_array[addr_index] <= mem_readdata;
            tag_array[addr_index]  <= addr_tag;
        end else if (write_hit) begin
            data_array[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_miss;

    // Hits that merely finish a refilled miss are not counted as hits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            after_miss <= 1'b0;
        end else begin
            if (state == UPDATE) after_miss <= 1'b1;
            if ((state == IDLE) && request && hit) begin
                after_miss <= 1'b0;
                if (!after_miss && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
            end
            if ((state == IDLE) && request && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the ALU. The ALU RESULT is the byte address for load/store instructions. Serves CPU byte reads/writes in one cycle on hit. On miss, stalls the CPU through BUSYWAIT while a block-level FSM writes back a dirty victim and refills from data memory. Data memory is a 32-bit-block, multi-cycle device with its own busywait.

Parameters:
INDEX_BITS, 3, log2 of number of cache blocks (8 blocks); tag width = 8 - 2 - INDEX_BITS
BLOCK_BYTES, 4, bytes per block; fixed, offset is ADDRESS[1:0]

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
READ  input  1  CPU load request (level, held until BUSYWAIT low)
WRITE  input  1  CPU store request (level, held until BUSYWAIT low)
ADDRESS  input  8  byte address from ALU RESULT: tag[7:5], index[4:2], offset[1:0]
WRITEDATA  input  8  store data
READDATA  output  8  load data
BUSYWAIT  output  1  CPU stall request
mem_read  output  1  memory block read request
mem_write  output  1  memory block write request
mem_address  output  6  memory block address {tag,index}
mem_writedata  output  32  victim block to memory
mem_readdata  input  32  refill block from memory
mem_busywait  input  1  memory busy; transfer complete when low while request is high

Behaviour:
- Storage per block: valid, dirty, tag[2:0], data[31:0]; byte k = data[8k+7:8k].
- Hit = valid[index] & (tag[index] == ADDRESS[7:5]). Evaluated combinationally.
- Read hit: READDATA = selected byte, combinational in same cycle; BUSYWAIT stays 0; no state change.
- Write hit: byte written and dirty set at next rising edge; BUSYWAIT 0.
- READ and WRITE both high: treated as WRITE. Neither high: BUSYWAIT 0, no action.
- BUSYWAIT = (READ|WRITE) & ~hit in IDLE, or state != IDLE. Combinational.
- FSM states and transitions:
  - IDLE: on request & miss, go to WRITE_BACK if the victim is valid & dirty, otherwise MEM_READ.
  - WRITE_BACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim data. When mem_busywait=0 at an edge, go to MEM_READ.
  - MEM_READ: mem_read=1, mem_address=ADDRESS[7:2]. When mem_busywait=0 at an edge, go to UPDATE.
  - UPDATE: at the edge, load mem_readdata into the block, set tag and valid, clear dirty, go to IDLE. The next cycle is a hit: reads complete, writes set dirty.
- mem_read and mem_write are never high together and are 0 in IDLE and UPDATE.
- Miss latency, clean: 1 (IDLE) + memory read cycles + 1 (UPDATE) before BUSYWAIT falls.
- Reset (async): FSM to IDLE, all valid and dirty bits 0, mem_read=0, mem_write=0, READDATA=0.
  - Reset mid-transaction aborts immediately; no partial block is written.
- Data array contents are not cleared by reset; data with valid=0 is never returned.
- Address and requests must be stable while BUSYWAIT=1. A change during a miss is undefined.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0.
  - hit_count increments on each cycle where a request completes in IDLE with hit and no preceding miss.
  - miss_count increments once per IDLE-to-miss transition.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then READ addr 8'h14 with memory returning 32'hDDCCBBAA after 4 busy cycles -> mem_read with mem_address 6'h05; BUSYWAIT high until UPDATE completes; then READDATA 8'hAA, BUSYWAIT 0.
2. Following READ 8'h17 -> hit, READDATA 8'hDD in same cycle, no mem activity.
3. WRITE 8'h55 to 8'h15 -> hit, no stall; subsequent READ 8'h15 returns 8'h55; block dirty.
4. READ 8'h34 (same index 5, tag 1) -> WRITE_BACK with mem_address 6'h05, mem_writedata 32'hDDCC55AA; then MEM_READ with mem_address 6'h0D; correct byte returned.
5. WRITE miss to clean block 8'h40 with data 8'h77 -> refill from 6'h10, then byte 0 written; READ 8'h40 returns 8'h77 with no stall.
6. Assert RESET during MEM_READ -> mem_read drops immediately, BUSYWAIT 0 with no request; prior hit address now misses.
